// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte-write strobe from the pipeline plus serial line and FIFO status back.
interface uart_tx_serializer_if #(
    parameter int FIFO_DEPTH = 16
);
    logic [7:0]                  uart;
    logic                        uartWe;
    logic                        txd;
    logic                        busy;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] fifoCount;
    logic                        overflow;
    modport master (output uart, uartWe, input txd, busy, full, fifoCount, overflow);
    modport slave (input uart, uartWe, output txd, busy, full, fifoCount, overflow);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: FIFO-buffered 8N1 transmitter with back-to-back frames and sticky overflow.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input logic                 clk,
    input logic                 rst,
    uart_tx_serializer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d, ovf_q, ovf_d;
    logic          full, empty, bit_end, pop, push;
    assign full  = count_q == DEPTH;
    assign empty = count_q == '0;
    always_comb begin
        bit_end = baud_q == LAST;
        pop     = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
        push    = bus.uartWe && (!full || pop);
        ovf_d   = ovf_q || (bus.uartWe && !push);
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE:  baud_d = '0;
            START: state_d = bit_end ? DATA : START;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 1'b1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP:  state_d = bit_end ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
        // a pop from IDLE or the last stop cycle starts the next frame immediately
        if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_ptr_q];
            baud_d  = '0;
            bit_d   = '0;
        end
        txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ovf_q    <= ovf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.uart;
    end
    assign bus.txd       = txd_q;
    assign bus.busy      = state_q != IDLE || !empty;
    assign bus.full      = full;
    assign bus.fifoCount = count_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: random and directed stimulus against a frame-timeline model with a decoding scoreboard.
module tb_uart_tx_serializer;
    localparam int C = 4;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uart_tx_serializer_if #(.FIFO_DEPTH(D)) bus ();
    uart_tx_serializer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int left = 0;
    logic [7:0] cur = '0;
    logic m_ovf = 1'b0;
    bit chk_en = 1'b0;
    bit mon_abort = 1'b0;
    int cyc_n = 0;
    int starts[$];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask
    // left = cycles remaining in the frame on the line, counting the current one
    task automatic model_step(input logic we, input logic [7:0] d, input logic r);
        bit pop, acc;
        if (r) begin
            mq.delete();
            exp_q.delete();
            left = 0;
            m_ovf = 1'b0;
            mon_abort = 1'b1;
            return;
        end
        pop = mq.size() > 0 && left <= 1;
        acc = we && (mq.size() < D || pop);
        if (we && !acc) m_ovf = 1'b1;
        if (pop) begin
            cur = mq.pop_front();
            left = 10 * C;
        end else if (left > 0) left--;
        if (acc) begin
            mq.push_back(d);
            exp_q.push_back(d);
        end
    endtask
    function automatic int exp_txd();
        int s;
        if (left == 0) return 1;
        s = (10 * C - left) / C;
        return s == 0 ? 0 : s == 9 ? 1 : int'(cur[s-1]);
    endfunction
    task automatic cyc(input logic we, input logic [7:0] d, input logic r);
        bus.uartWe = we;
        bus.uart = d;
        rst = r;
        @(posedge clk);
        model_step(we, d, r);
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0);
    endtask
    initial begin
        int t;
        logic [7:0] rx;
        t = -1;
        rx = '0;
        forever begin
            @(negedge clk);
            if (mon_abort) begin
                t = -1;
                mon_abort = 1'b0;
            end
            if (chk_en) begin
                cyc_n++;
                chk("txd", int'(bus.txd), exp_txd());
                chk("busy", int'(bus.busy), int'(left > 0 || mq.size() > 0));
                chk("fifoCount", int'(bus.fifoCount), mq.size());
                chk("full", int'(bus.full), int'(mq.size() == D));
                chk("overflow", int'(bus.overflow), int'(m_ovf));
                if (t >= 10 * C) t = -1;
                if (t < 0 && bus.txd == 1'b0) begin
                    t = 0;
                    starts.push_back(cyc_n);
                end
                if (t >= 0) begin
                    if (t % C == C / 2 && t / C >= 1 && t / C <= 8) rx[t/C-1] = bus.txd;
                    if (t % C == C / 2 && t / C == 9) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_unexpected: got %02h expected no frame", rx);
                        end else begin
                            chk("frame_byte", int'(rx), int'(exp_q.pop_front()));
                            chk("stop_bit", int'(bus.txd), 1);
                        end
                    end
                    t++;
                end
            end
        end
    end
    initial begin
        int n0;
        bus.uartWe = 1'b0;
        bus.uart = '0;
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk_en = 1'b1;
        chk("reset_txd", int'(bus.txd), 1);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_count", int'(bus.fifoCount), 0);
        // single byte
        cyc(1'b1, 8'hA5, 1'b0);
        idle(45);
        chk("single_busy_done", int'(bus.busy), 0);
        // back-to-back frames
        n0 = starts.size();
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0);
        idle(100);
        chk("b2b_frames", starts.size() - n0, 2);
        if (starts.size() - n0 == 2) chk("b2b_gap", starts[n0+1] - starts[n0], 10 * C);
        // overflow
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("ovf_set", int'(bus.overflow), 1);
        chk("ovf_full", int'(bus.full), 1);
        idle(10 * C * 6);
        chk("ovf_sticky", int'(bus.overflow), 1);
        // push while full on the final stop cycle
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        chk("pre_full", int'(bus.full), 1);
        for (int i = 0; i < 100 && left != 1; i++) cyc(1'b0, 8'h00, 1'b0);
        chk("reached_stop_end", left, 1);
        cyc(1'b1, 8'h99, 1'b0);
        chk("fullpop_count", int'(bus.fifoCount), D);
        chk("fullpop_ovf", int'(bus.overflow), 0);
        idle(10 * C * 6);
        // reset mid-frame during data bit 3
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h3C, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 100 && 10 * C - left != 4 * C + 1; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("rst_mid_txd", int'(bus.txd), 1);
        chk("rst_mid_count", int'(bus.fifoCount), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_ovf", int'(bus.overflow), 0);
        n0 = starts.size();
        idle(100);
        chk("rst_mid_no_frames", starts.size() - n0, 0);
        // idle stability with a toggling, partly undefined data bus
        idle(195);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'bx, 1'b0);
        chk("idle_frames", starts.size() - n0, 0);
        // random bursts
        for (int i = 0; i < 1500; i++) begin
            int thr;
            thr = (i / 100) % 2 == 1 ? 8 : 1;
            cyc(1'b0 + ($urandom_range(0, 9) < thr), 8'($urandom), 1'b0);
        end
        idle(10 * C * (D + 2));
        chk("drain_exp_q", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
